// File: rtl/timetag_recorder.sv
// rtl/timetag_recorder.sv - strobe time-tagger with FWFT record FIFO; TIMETAG_LOST_COUNT_EN adds lost_count
module timetag_recorder #(
    parameter int CHANNELS   = 4,
    parameter int TIME_WIDTH = 24,
    parameter int DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            strobe,
    input  logic                           enable,
    output logic [CHANNELS+TIME_WIDTH:0]   rec_data,
    output logic                           rec_valid,
    input  logic                           rec_ready,
    output logic [$clog2(DEPTH):0]         fifo_count,
    output logic                           overflow,
    input  logic                           clear_overflow
`ifdef TIMETAG_LOST_COUNT_EN
    ,
    output logic [15:0]                    lost_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 1 + CHANNELS + TIME_WIDTH;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [TIME_WIDTH-1:0] counter;
    logic [RW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wrap;
    logic                  push_req;
    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    assign wrap      = &counter;
    assign push_req  = enable && ((|strobe) || wrap);
    assign full      = (fifo_count == FULL_COUNT);
    assign rec_valid = (fifo_count != '0);
    assign pop       = rec_valid && rec_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en     = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign rec_data  = rec_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (enable)
                counter <= counter + 1'b1;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !wr_en)
                fifo_count <= fifo_count - 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

    // Storage needs no reset: contents are only visible through rec_valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= {wrap, strobe, counter};
    end

`ifdef TIMETAG_LOST_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lost_count <= '0;
        else if (clear_overflow)
            lost_count <= drop ? 16'd1 : 16'd0;
        else if (drop && lost_count != 16'hFFFF)
            lost_count <= lost_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_timetag_recorder.sv
// tb/tb_timetag_recorder.sv - randomized self-checking bench for timetag_recorder with a queue model
module tb_timetag_recorder;
    localparam int CH = 4;
    localparam int TW = 4;
    localparam int DP = 4;
    localparam int RW = 1 + CH + TW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] strobe = '0;
    logic          enable = 1'b0;
    logic [RW-1:0] rec_data;
    logic          rec_valid;
    logic          rec_ready = 1'b0;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          clear_overflow = 1'b0;
`ifdef TIMETAG_LOST_COUNT_EN
    logic [15:0]   lost_count;
`endif

    timetag_recorder #(.CHANNELS(CH), .TIME_WIDTH(TW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .enable(enable),
        .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
`ifdef TIMETAG_LOST_COUNT_EN
        , .lost_count(lost_count)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass = 0;
    logic [RW-1:0] m_q[$];
    int            m_time = 0;
    bit            m_ovf = 0;
    int            m_lost = 0;

    function automatic logic [RW-1:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : '0;
    endfunction

    // Drive one cycle of inputs, advance the reference model, sample #1 after the edge.
    task automatic cycle(input logic [CH-1:0] s, input logic en, input logic rdy, input logic clr);
        bit wr, push, pop, drop;
        strobe = s; enable = en; rec_ready = rdy; clear_overflow = clr;
        wr   = en && (m_time == (1 << TW) - 1);
        push = en && (s != 0 || wr);
        pop  = rdy && (m_q.size() > 0);
        drop = push && (m_q.size() == DP) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back({wr, s, 4'(m_time)});
        if (clr) begin m_ovf = 0; m_lost = 0; end
        if (drop) begin m_ovf = 1; if (m_lost < 65535) m_lost++; end
        if (en) m_time = (m_time + 1) % (1 << TW);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        while (m_q.size() > 0) cycle('0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (rec_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rec_valid); else n_pass++;
        n_checks++; if (rec_data !== '0) $display("FAIL reset_data: got %h expected 0", rec_data); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", overflow); else n_pass++;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_first_record();
        while (m_time != 5) cycle('0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        n_checks++; if (rec_valid !== 1'b1) $display("FAIL first_valid: got %b expected 1", rec_valid); else n_pass++;
        n_checks++; if (rec_data !== 9'b0_0010_0101) $display("FAIL first_data: got %h expected %h", rec_data, 9'b0_0010_0101); else n_pass++;
        n_checks++; if (fifo_count !== 3'd1) $display("FAIL first_count: got %0d expected 1", fifo_count); else n_pass++;
        cycle('0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL first_pop: got %0d expected 0", fifo_count); else n_pass++;
    endtask

    task automatic test_wrap();
        repeat (32) cycle('0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (fifo_count !== 3'd2) $display("FAIL wrap_count: got %0d expected 2", fifo_count); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (rec_data !== 9'b1_0000_1111) $display("FAIL wrap_data%0d: got %h expected %h", i, rec_data, 9'b1_0000_1111); else n_pass++;
            cycle('0, 1'b0, 1'b1, 1'b0);
        end
        while (m_time != 15) cycle('0, 1'b1, 1'b0, 1'b0);
        cycle(4'b1001, 1'b1, 1'b0, 1'b0);
        n_checks++; if (fifo_count !== 3'd1) $display("FAIL wrap_strobe_count: got %0d expected 1", fifo_count); else n_pass++;
        n_checks++; if (rec_data !== 9'b1_1001_1111) $display("FAIL wrap_strobe_data: got %h expected %h", rec_data, 9'b1_1001_1111); else n_pass++;
        drain();
    endtask

    task automatic test_overflow();
        int t;
        t = m_time;
        repeat (6) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        n_checks++; if (fifo_count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", fifo_count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
`ifdef TIMETAG_LOST_COUNT_EN
        n_checks++; if (lost_count !== 16'd2) $display("FAIL ovf_lost: got %0d expected 2", lost_count); else n_pass++;
`endif
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rec_data[TW-1:0] !== 4'((t + i) % 16) || rec_data[RW-2:TW] !== 4'b0001)
                $display("FAIL ovf_order%0d: got %h expected time %0d mask 1", i, rec_data, (t + i) % 16); else n_pass++;
            cycle('0, 1'b0, 1'b1, 1'b0);
        end
        cycle('0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow); else n_pass++;
    endtask

    task automatic test_full_push_pop();
        repeat (4) cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        cycle(4'b0010, 1'b1, 1'b1, 1'b0);
        n_checks++; if (fifo_count !== 3'd4) $display("FAIL fpp_count: got %0d expected 4", fifo_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fpp_ovf: got %b expected 0", overflow); else n_pass++;
        n_checks++; if (rec_data !== m_head()) $display("FAIL fpp_head: got %h expected %h", rec_data, m_head()); else n_pass++;
        cycle(4'b0010, 1'b1, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b1) $display("FAIL fpp_set_wins: got %b expected 1", overflow); else n_pass++;
`ifdef TIMETAG_LOST_COUNT_EN
        n_checks++; if (lost_count !== 16'd1) $display("FAIL fpp_lost: got %0d expected 1", lost_count); else n_pass++;
`endif
        drain();
        cycle('0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_enable_hold();
        int held;
        held = m_time;
        repeat (10) begin
            cycle(4'b1111, 1'b0, 1'b0, 1'b0);
            n_checks++; if (rec_valid !== 1'b0 || fifo_count !== 3'd0)
                $display("FAIL hold_norec: got valid %b count %0d expected 0 0", rec_valid, fifo_count); else n_pass++;
        end
        cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        n_checks++; if (rec_data[TW-1:0] !== 4'(held)) $display("FAIL hold_resume: got %0d expected %0d", rec_data[TW-1:0], held); else n_pass++;
        drain();
    endtask

    task automatic test_random();
        logic [CH-1:0] s;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 2) == 0) ? CH'($urandom) : '0;
            cycle(s, $urandom_range(0, 7) != 0, (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 15) == 0);
            n_checks++; if (rec_valid !== (m_q.size() > 0)) $display("FAIL rnd_valid@%0d: got %b expected %b", i, rec_valid, m_q.size() > 0); else n_pass++;
            n_checks++; if (rec_data !== m_head()) $display("FAIL rnd_data@%0d: got %h expected %h", i, rec_data, m_head()); else n_pass++;
            n_checks++; if (fifo_count !== 3'(m_q.size())) $display("FAIL rnd_count@%0d: got %0d expected %0d", i, fifo_count, m_q.size()); else n_pass++;
            n_checks++; if (overflow !== m_ovf) $display("FAIL rnd_ovf@%0d: got %b expected %b", i, overflow, m_ovf); else n_pass++;
`ifdef TIMETAG_LOST_COUNT_EN
            n_checks++; if (lost_count !== 16'(m_lost)) $display("FAIL rnd_lost@%0d: got %0d expected %0d", i, lost_count, m_lost); else n_pass++;
`endif
        end
        drain();
        cycle('0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        repeat (5) cycle(4'b0001, 1'b1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (fifo_count !== 3'd3 || overflow !== 1'b1)
            $display("FAIL arst_setup: got count %0d ovf %b expected 3 1", fifo_count, overflow); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (rec_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", rec_valid); else n_pass++;
        n_checks++; if (fifo_count !== 3'd0) $display("FAIL arst_count: got %0d expected 0", fifo_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL arst_ovf: got %b expected 0", overflow); else n_pass++;
        m_q.delete(); m_time = 0; m_ovf = 0; m_lost = 0;
        @(posedge clk); #1; rst = 1'b0;
        cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        n_checks++; if (rec_data !== 9'b0_0100_0000) $display("FAIL arst_time0: got %h expected %h", rec_data, 9'b0_0100_0000); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_record();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_enable_hold();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
